// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 serial receiver with optional even parity, which turns it into 8E1.
//            Define UART_RX_PARITY_EN to enable the parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int BAUD = 115200,
  parameter int F    = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = F / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(HALF_BIT - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd5;
`endif

  generate
    if (CLKS_PER_BIT < 4) begin : g_cfg_check
      $error("uart_rx: F/BAUD must be at least 4");
    end
  endgenerate

  logic          sync1;
  logic          sync2;
  logic          rxs;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bidx;
  logic [7:0]    shreg;
  logic          par_ok;

  // rx is asynchronous to clk; only the second flop's output is ever used
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
    end
  end

  assign rxs  = sync2;
  assign busy = (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_err_r;

  // Even parity: data bits plus parity bit must XOR to zero
  assign par_ok     = ~(^{shreg, par_bit});
  assign parity_err = par_err_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bit   <= 1'b0;
      par_err_r <= 1'b0;
    end else begin
      par_err_r <= 1'b0;
      if (state == ST_PARITY && cnt == C_BIT_LAST) begin
        par_bit <= rxs;
      end
      if (state == ST_STOP && cnt == C_BIT_LAST && rxs && !par_ok) begin
        par_err_r <= 1'b1;
      end
    end
  end
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bidx      <= 3'd0;
      shreg     <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rxs) begin
            state <= ST_START;
          end
        end

        ST_START: begin
          if (cnt == C_HALF_LAST) begin
            cnt <= '0;
            if (rxs) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_DATA;
              bidx  <= 3'd0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_DATA: begin
          if (cnt == C_BIT_LAST) begin
            cnt         <= '0;
            shreg[bidx] <= rxs;
            if (bidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              bidx <= bidx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt == C_BIT_LAST) begin
            cnt   <= '0;
            state <= ST_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif

        // Leaving at the stop-bit centre leaves half a bit to catch a
        // start edge that immediately follows
        ST_STOP: begin
          if (cnt == C_BIT_LAST) begin
            cnt <= '0;
            if (rxs) begin
              state <= ST_IDLE;
              if (par_ok) begin
                data  <= shreg;
                valid <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_BREAK: begin
          cnt <= '0;
          if (rxs) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : directed self-checking bench for uart_rx at 16 clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int         cyc      = 0;
  int         n_ferr   = 0;
  int         n_perr   = 0;
  int         n_multi  = 0;
  logic       busy_seen = 1'b0;
  logic [7:0] vq[$];
  int         vt[$];

`ifdef UART_RX_PARITY_EN
  localparam int FRAME_CLKS = 176;
`else
  localparam int FRAME_CLKS = 160;
`endif

  uart_rx #(.BAUD(1), .F(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Strobe recorder, sampled on the falling edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (valid) begin
        vq.push_back(data);
        vt.push_back(cyc);
      end
      if (frame_err) n_ferr = n_ferr + 1;
      if (parity_err) n_perr = n_perr + 1;
      if (busy) busy_seen = 1'b1;
      if (32'(valid) + 32'(frame_err) + 32'(parity_err) > 1) n_multi = n_multi + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_bit);
`else
    if (par_bit) begin end
`endif
    send_bit(stop_bit);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int nv;

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_perr", 32'(parity_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    idle(4);

    // Single byte
    send_frame(8'hA5, 1'b1, ^8'hA5);
    idle(8);
    chk("a5_nvalid", 32'(vq.size()), 32'd1);
    if (vq.size() >= 1) chk("a5_data", 32'(vq[0]), 32'hA5);
    chk("a5_hold", 32'(data), 32'hA5);
    chk("a5_ferr", 32'(n_ferr), 32'd0);
    chk("a5_busy", 32'(busy), 32'd0);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(8);
    chk("b2b_nvalid", 32'(vq.size()), 32'd3);
    if (vq.size() >= 3) begin
      chk("b2b_d0", 32'(vq[1]), 32'h00);
      chk("b2b_d1", 32'(vq[2]), 32'hFF);
      chk("b2b_gap", 32'((vt[2] - vt[1] >= FRAME_CLKS - 2) && (vt[2] - vt[1] <= FRAME_CLKS + 2)), 32'd1);
    end

    // Glitch shorter than half a bit
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(30);
    chk("glitch_nvalid", 32'(vq.size()), 32'd3);
    chk("glitch_busy_seen", 32'(busy_seen), 32'd1);
    chk("glitch_idle", 32'(busy), 32'd0);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    idle(8);
    chk("glitch_next_n", 32'(vq.size()), 32'd4);
    chk("glitch_next_d", 32'(data), 32'h3C);

    // Bad stop bit followed by a held-low line
    send_frame(8'h55, 1'b0, ^8'h55);
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("brk_ferr", 32'(n_ferr), 32'd1);
    chk("brk_nvalid", 32'(vq.size()), 32'd4);
    chk("brk_data_hold", 32'(data), 32'h3C);
    chk("brk_busy", 32'(busy), 32'd1);
    idle(20);
    chk("brk_exit_idle", 32'(busy), 32'd0);
    chk("brk_no_extra", 32'(n_ferr + vq.size()), 32'd5);
    send_frame(8'h12, 1'b1, ^8'h12);
    idle(8);
    chk("brk_next_d", 32'(data), 32'h12);
    chk("brk_next_n", 32'(vq.size()), 32'd5);

    // Asynchronous reset in the middle of bit 4 of 0x81
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1 & (8'h81 >> i));
    rx = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_data", 32'(data), 32'h00);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(20);
    nv = vq.size();
    chk("arst_no_strobe", 32'(nv), 32'd5);
    send_frame(8'h7E, 1'b1, ^8'h7E);
    idle(8);
    chk("arst_next_n", 32'(vq.size()), 32'd6);
    chk("arst_next_d", 32'(data), 32'h7E);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b0);
    idle(8);
    chk("par_ok_n", 32'(vq.size()), 32'd7);
    chk("par_ok_d", 32'(data), 32'h03);
    send_frame(8'h03, 1'b1, 1'b1);
    idle(8);
    chk("par_bad_perr", 32'(n_perr), 32'd1);
    chk("par_bad_nvalid", 32'(vq.size()), 32'd7);
    chk("par_bad_data", 32'(data), 32'h03);
`else
    chk("nopar_perr", 32'(n_perr), 32'd0);
`endif

    chk("strobe_exclusive", 32'(n_multi), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
